// File: rtl/rr_arbiter_8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef logic [N_REQ-1:0] req_vec_t;

    // Index of the set bit in a one-hot vector; zero input yields zero.
    function automatic logic [IDX_W-1:0] onehot_idx(input req_vec_t oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_8_if;
    import arb_pkg::*;

    req_vec_t         req_i;
    logic             ack_i;
    req_vec_t         gnt_o;
    logic             gnt_valid_o;
    logic             timeout_o;
    logic [IDX_W-1:0] ptr_o;

    modport slave (
        input  req_i, ack_i,
        output gnt_o, gnt_valid_o, timeout_o, ptr_o
    );

    modport master (
        output req_i, ack_i,
        input  gnt_o, gnt_valid_o, timeout_o, ptr_o
    );
endinterface

// File: rtl/rr_arbiter_8_pick.sv
// Round-robin pick: rotate requests so ptr sits at bit 0, isolate the lowest
// set bit, then rotate the result back into place.
module rr_priority_pick
    import arb_pkg::*;
(
    input  req_vec_t         req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output req_vec_t         onehot_o,
    output logic             any_o
);

    logic [2*N_REQ-1:0] dbl_req;
    logic [2*N_REQ-1:0] dbl_oh;
    req_vec_t           rot;
    req_vec_t           rot_oh;

    assign dbl_req  = {req_i, req_i} >> ptr_i;
    assign rot      = dbl_req[N_REQ-1:0];
    // Two's-complement trick keeps only the lowest set bit.
    assign rot_oh   = rot & (~rot + req_vec_t'(1));
    assign dbl_oh   = {rot_oh, rot_oh} << ptr_i;
    assign onehot_o = dbl_oh[2*N_REQ-1:N_REQ];
    assign any_o    = |req_i;

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter: registered one-hot grant held until ack,
// withdraw or hold timeout; pointer advances past the winner on release.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    rr_arbiter_8_if.slave    bus
);

    if (N_REQ != arb_pkg::N_REQ) begin : g_bad_n_req
        $error("rr_arbiter_8: N_REQ must be 8");
    end

    localparam int               CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_HOLD);

    arb_state_t       state_q, state_d;
    req_vec_t         gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    req_vec_t pick_oh;
    logic     pick_any;
    logic     hold_expired;
    logic     withdrawn;

    rr_priority_pick u_pick (
        .req_i    (bus.req_i),
        .ptr_i    (ptr_q),
        .onehot_o (pick_oh),
        .any_o    (pick_any)
    );

    assign hold_expired = (MAX_HOLD > 0) && (cnt_q == CNT_LAST);
    assign withdrawn    = (gnt_q & bus.req_i) == '0;

    // NOTE: every always_comb output is defaulted first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                if (pick_any) begin
                    gnt_d       = pick_oh;
                    gnt_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                // Ack beats timeout beats withdraw; all three release the grant.
                if (bus.ack_i || hold_expired || withdrawn) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    timeout_d   = !bus.ack_i && hold_expired;
                    ptr_d       = onehot_idx(gnt_q) + IDX_W'(1);
                    state_d     = IDLE;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its peers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            ptr_q       <= ptr_d;
            cnt_q       <= (MAX_HOLD > 0) ? cnt_d : '0;
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.gnt_valid_o = gnt_valid_q;
    assign bus.timeout_o   = timeout_q;
    assign bus.ptr_o       = ptr_q;

    a_valid_matches_gnt : assert property (@(posedge clk_i) bus.gnt_valid_o == (bus.gnt_o != '0));
    a_gnt_onehot0       : assert property (@(posedge clk_i) $onehot0(bus.gnt_o));

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 (MAX_HOLD=4): the driver pushes the expected
// post-edge outputs for each vector, a monitor pops and compares after each edge.
module tb_rr_arbiter_8;
    import arb_pkg::*;

    typedef struct {
        req_vec_t         gnt;
        logic             tmo;
        logic [IDX_W-1:0] ptr;
        string            name;
    } exp_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    rr_arbiter_8_if bus ();

    rr_arbiter_8 #(.N_REQ(8), .MAX_HOLD(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; expectation is for the
    // outputs registered by the following rising edge.
    task automatic step(input logic r, input req_vec_t req, input logic ack,
                        input req_vec_t gnt, input logic tmo, input logic [IDX_W-1:0] ptr,
                        input string name);
        exp_t e;
        @(negedge clk);
        rst       = r;
        bus.req_i = req;
        bus.ack_i = ack;
        e.gnt  = gnt;
        e.tmo  = tmo;
        e.ptr  = ptr;
        e.name = name;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".gnt"},   32'(bus.gnt_o),       32'(e.gnt));
                check({e.name, ".valid"}, 32'(bus.gnt_valid_o), 32'(e.gnt != '0));
                check({e.name, ".tmo"},   32'(bus.timeout_o),   32'(e.tmo));
                check({e.name, ".ptr"},   32'(bus.ptr_o),       32'(e.ptr));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        rst       = 1'b1;
        bus.req_i = 8'hFF;
        bus.ack_i = 1'b1;

        // Reset overrides requests and ack; first grant one cycle after release.
        step(1, 8'hFF, 1, 8'h00, 0, 3'd0, "rst_a");
        step(1, 8'hFF, 1, 8'h00, 0, 3'd0, "rst_b");
        step(0, 8'hFF, 0, 8'h01, 0, 3'd0, "first_gnt");
        step(0, 8'hFF, 1, 8'h00, 0, 3'd1, "first_ack");

        // Wrap priority from ptr=0.
        step(1, 8'h00, 0, 8'h00, 0, 3'd0, "rst_wrap");
        step(0, 8'h81, 0, 8'h01, 0, 3'd0, "wrap_g0");
        step(0, 8'h81, 1, 8'h00, 0, 3'd1, "wrap_ack0");
        step(0, 8'h81, 0, 8'h80, 0, 3'd1, "wrap_g7");
        step(0, 8'h81, 1, 8'h00, 0, 3'd0, "wrap_ack7");

        // Fairness: all requesting, ack on each grant cycle.
        for (int k = 0; k < 8; k++) begin
            step(0, 8'hFF, 0, req_vec_t'(1) << k, 0, 3'(k),     $sformatf("fair_g%0d", k));
            step(0, 8'hFF, 1, 8'h00,              0, 3'(k + 1), $sformatf("fair_ack%0d", k));
        end
        step(0, 8'hFF, 0, 8'h01, 0, 3'd0, "fair_wrap");
        step(0, 8'h00, 1, 8'h00, 0, 3'd1, "fair_done");

        // Timeout: grant held 4 cycles, one-cycle pulse, pointer past bit 4.
        for (int k = 0; k < 4; k++)
            step(0, 8'h10, 0, 8'h10, 0, 3'd1, $sformatf("to_hold%0d", k));
        step(0, 8'h10, 0, 8'h00, 1, 3'd5, "to_pulse");
        step(0, 8'h10, 0, 8'h10, 0, 3'd5, "to_regrant");
        step(0, 8'h00, 0, 8'h00, 0, 3'd5, "to_withdraw");

        // Withdraw, then ack coinciding with the drop.
        step(0, 8'h04, 0, 8'h04, 0, 3'd5, "wd_gnt");
        step(0, 8'h00, 0, 8'h00, 0, 3'd3, "wd_drop");
        step(0, 8'h04, 0, 8'h04, 0, 3'd3, "wda_gnt");
        step(0, 8'h00, 1, 8'h00, 0, 3'd3, "wda_drop");

        // Other requesters appearing mid-grant do not disturb it.
        step(0, 8'h20, 0, 8'h20, 0, 3'd3, "mid_gnt");
        step(0, 8'hFF, 0, 8'h20, 0, 3'd3, "mid_others");

        // Reset mid-grant wins over ack.
        step(1, 8'h20, 1, 8'h00, 0, 3'd0, "rst_mid");
        step(1, 8'h00, 0, 8'h00, 0, 3'd0, "rst_mid_hold");

        // Ack while idle is ignored.
        step(0, 8'h00, 1, 8'h00, 0, 3'd0, "idle_ack");

        repeat (3) @(posedge clk);
        #3;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
